next_pc_unit: RTL

//   Parametrised next-PC / jump resolution unit; successor to the single-mode jump block.
//   - Resolves SEQ, J, JAL, JR, BEQ, BNE and RET per request through an en/jump_done handshake.
//   - Keeps a circular return-address stack (RAS) for JAL/RET.
//   - Sits between decode and the PC register of the multicycle MIPS core.

---
 rtl/next_pc_unit_if.sv | 43 ++++
 rtl/next_pc_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/next_pc_unit_if.sv
// rtl/next_pc_unit_if.sv - request/response bundle between decode and next_pc_unit
// misalign is present only when NPC_ALIGN_CHECK_EN is defined.
interface next_pc_unit_if #(
  parameter int XLEN = 32
);
  logic            en;
  logic [2:0]      op;
  logic [XLEN-1:0] pc;
  logic [25:0]     addr;
  logic [15:0]     imm;
  logic [XLEN-1:0] reg_addr;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] link_addr;
  logic            link_we;
  logic            taken;
  logic            jump_done;
  logic            busy;
  logic            ras_empty;
  logic            ras_full;
`ifdef NPC_ALIGN_CHECK_EN
  logic            misalign;

  modport master (
    output en, op, pc, addr, imm, reg_addr, rs_val, rt_val,
    input  pc_out, link_addr, link_we, taken, jump_done, busy, ras_empty, ras_full, misalign
  );
  modport slave (
    input  en, op, pc, addr, imm, reg_addr, rs_val, rt_val,
    output pc_out, link_addr, link_we, taken, jump_done, busy, ras_empty, ras_full, misalign
  );
`else
  modport master (
    output en, op, pc, addr, imm, reg_addr, rs_val, rt_val,
    input  pc_out, link_addr, link_we, taken, jump_done, busy, ras_empty, ras_full
  );
  modport slave (
    input  en, op, pc, addr, imm, reg_addr, rs_val, rt_val,
    output pc_out, link_addr, link_we, taken, jump_done, busy, ras_empty, ras_full
  );
`endif
endinterface

// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - next-PC / jump resolution with circular return-address stack
// Optional target alignment check enabled by defining NPC_ALIGN_CHECK_EN.
module next_pc_unit #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  next_pc_unit_if.slave bus
);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [2:0] OP_J   = 3'd1;
  localparam logic [2:0] OP_JAL = 3'd2;
  localparam logic [2:0] OP_JR  = 3'd3;
  localparam logic [2:0] OP_BEQ = 3'd4;
  localparam logic [2:0] OP_BNE = 3'd5;
  localparam logic [2:0] OP_RET = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q;
  logic [XLEN-1:0] pc_q, reg_addr_q, rs_q, rt_q;
  logic [25:0]     addr_q;
  logic [15:0]     imm_q;
  logic [XLEN-1:0] pc_out_q, link_q;
  logic            taken_q;
  logic            misalign_q;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q;
  logic [PW:0]     cnt_q;

  logic [XLEN-1:0] p4, jtarget, btarget, target_d;
  logic            taken_d, push_d, pop_d, mis_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.en) state_d = S_CALC;
      S_CALC:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    p4       = pc_q + XLEN'(4);
    jtarget  = {p4[XLEN-1:28], addr_q, 2'b00};
    btarget  = p4 + {{(XLEN-18){imm_q[15]}}, imm_q, 2'b00};
    target_d = p4;
    taken_d  = 1'b0;
    push_d   = 1'b0;
    pop_d    = 1'b0;
    mis_d    = 1'b0;
    case (op_q)
      OP_J:   begin target_d = jtarget; taken_d = 1'b1; end
      OP_JAL: begin target_d = jtarget; taken_d = 1'b1; push_d = 1'b1; end
      OP_JR:  begin target_d = reg_addr_q; taken_d = 1'b1; end
      OP_BEQ: if (rs_q == rt_q) begin target_d = btarget; taken_d = 1'b1; end
      OP_BNE: if (rs_q != rt_q) begin target_d = btarget; taken_d = 1'b1; end
      OP_RET: begin
        taken_d = 1'b1;
        // An empty stack falls back to the register target without touching state.
        if (cnt_q != '0) begin
          target_d = ras_q[ptr_q - PW'(1)];
          pop_d    = 1'b1;
        end else begin
          target_d = reg_addr_q;
        end
      end
      default: ;
    endcase
`ifdef NPC_ALIGN_CHECK_EN
    if (target_d[1:0] != 2'b00) begin
      mis_d    = 1'b1;
      target_d = p4;
      taken_d  = 1'b0;
      push_d   = 1'b0;
      pop_d    = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      pc_q       <= '0;
      addr_q     <= '0;
      imm_q      <= '0;
      reg_addr_q <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      pc_out_q   <= '0;
      link_q     <= '0;
      taken_q    <= 1'b0;
      misalign_q <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && bus.en) begin
        op_q       <= bus.op;
        pc_q       <= bus.pc;
        addr_q     <= bus.addr;
        imm_q      <= bus.imm;
        reg_addr_q <= bus.reg_addr;
        rs_q       <= bus.rs_val;
        rt_q       <= bus.rt_val;
      end
      if (state_q == S_CALC) begin
        pc_out_q   <= target_d;
        taken_q    <= taken_d;
        link_q     <= p4;
        misalign_q <= mis_d;
        // Writing at ptr when full lands on the oldest slot, so overflow overwrites it.
        if (push_d) begin
          ras_q[ptr_q] <= p4;
          ptr_q        <= ptr_q + PW'(1);
          if (cnt_q != (PW+1)'(RAS_DEPTH)) cnt_q <= cnt_q + (PW+1)'(1);
        end else if (pop_d) begin
          ptr_q <= ptr_q - PW'(1);
          cnt_q <= cnt_q - (PW+1)'(1);
        end
      end
    end
  end

  assign bus.pc_out    = pc_out_q;
  assign bus.link_addr = link_q;
  assign bus.taken     = taken_q;
  assign bus.jump_done = (state_q == S_DONE);
  assign bus.link_we   = (state_q == S_DONE) && (op_q == OP_JAL) && !misalign_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.ras_empty = (cnt_q == '0);
  assign bus.ras_full  = (cnt_q == (PW+1)'(RAS_DEPTH));
`ifdef NPC_ALIGN_CHECK_EN
  assign bus.misalign  = (state_q == S_DONE) && misalign_q;
`else
  logic unused_mis;
  assign unused_mis = misalign_q ^ mis_d;
`endif
endmodule
